// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface.
// Bundles the eight functional-unit result requests with the single broadcast
// bus they compete for.
//   req       : per-unit result-ready request (bit i = functional unit i)
//   data_in   : unit i result on [i*WIDTH +: WIDTH]
//   tag_in    : unit i tag on [i*TAG_W +: TAG_W]
//   stall     : bus consumers cannot accept a broadcast this cycle
//   flush     : pipeline flush, cancels the pending broadcast
//   gnt       : one-hot grant, combinational
//   sel       : binary index of the granted unit
//   cdb_valid : registered broadcast valid
//   cdb_data  : registered broadcast data
//   cdb_tag   : registered broadcast tag
//   dbg_ptr   : current round-robin priority pointer (observability only)
// Modports: master = the functional-unit / consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic [7:0]         req;
  logic [8*WIDTH-1:0] data_in;
  logic [8*TAG_W-1:0] tag_in;
  logic               stall;
  logic               flush;
  logic [7:0]         gnt;
  logic [2:0]         sel;
  logic               cdb_valid;
  logic [WIDTH-1:0]   cdb_data;
  logic [TAG_W-1:0]   cdb_tag;
  logic [2:0]         dbg_ptr;

  modport master (
    output req, data_in, tag_in, stall, flush,
    input  gnt, sel, cdb_valid, cdb_data, cdb_tag, dbg_ptr
  );

  modport slave (
    input  req, data_in, tag_in, stall, flush,
    output gnt, sel, cdb_valid, cdb_data, cdb_tag, dbg_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus.
// Eight functional units request the bus. One is granted per cycle, searching
// upward from a 3-bit priority pointer with wrap-around. The granted unit's
// result and tag are registered onto the broadcast bus one cycle later.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cdb_arbiter_if.slave (requests, grant, broadcast outputs)
//
// Handshake: unit i holds req[i], its data and its tag stable until it sees
// gnt[i]=1 at a rising edge. That edge is the transfer. On the next cycle the
// unit either drops req[i] or presents a new result. No grant is issued while
// stall or flush is high, and a bit whose req is 0 is never granted.
module cdb_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  logic [2:0]       r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [TAG_W-1:0] r_tag;

  logic [7:0]       w_gnt;
  logic [2:0]       w_sel;
  logic [2:0]       w_idx;
  logic             w_found;

  // The grant is a pure function of req, stall, flush and ptr. The 3-bit add
  // wraps by itself, so the search visits ptr, ptr+1 .. ptr+7 modulo 8.
  always_comb begin
    w_gnt   = '0;
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (!bus.stall && !bus.flush) begin
      for (int k = 0; k < 8; k++) begin
        w_idx = r_ptr + 3'(k);
        if (!w_found && bus.req[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
          w_gnt   = 8'b1 << w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (bus.flush) begin
      // Flush cancels the broadcast. The pointer holds because no grant occurred.
      r_valid <= 1'b0;
    end else if (w_found) begin
      r_ptr   <= w_sel + 3'd1;
      r_valid <= 1'b1;
      r_data  <= bus.data_in[int'(w_sel)*WIDTH +: WIDTH];
      r_tag   <= bus.tag_in[int'(w_sel)*TAG_W +: TAG_W];
    end else if (!bus.stall) begin
      r_valid <= 1'b0;
    end
    // While stalled with no flush, all broadcast registers hold.
  end

  assign bus.gnt       = w_gnt;
  assign bus.sel       = w_sel;
  assign bus.cdb_valid = r_valid;
  assign bus.cdb_data  = r_data;
  assign bus.cdb_tag   = r_tag;
  assign bus.dbg_ptr   = r_ptr;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter WIDTH, 32: result data width per requester.
REQ-002 Parameter TAG_W, 6: result tag (reservation-station/ROB id) width.
REQ-003 clk  input  1  rising-edge clock; only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  8  per-unit result-ready request; bit i = functional unit i.
REQ-006 data_in  input  8*WIDTH  unit i result on bits [i*WIDTH +: WIDTH].
REQ-007 tag_in  input  8*TAG_W  unit i tag on bits [i*TAG_W +: TAG_W].
REQ-008 stall  input  1  bus consumers cannot accept a broadcast this cycle.
REQ-009 flush  input  1  pipeline flush; cancels the pending broadcast.
REQ-010 gnt  output  8  one-hot grant, combinational, same cycle as accepted req.
REQ-011 sel  output  3  binary index of granted unit; drives the 8:1 result mux select.
REQ-012 cdb_valid  output  1  registered broadcast valid.
REQ-013 cdb_data  output  WIDTH  registered broadcast data.
REQ-014 cdb_tag  output  TAG_W  registered broadcast tag.

Function
REQ-015 Arbitration SHALL be round-robin over 8 requesters with a 3-bit priority pointer ptr; highest priority = ptr, then ptr+1 ... ptr+7, modulo 8.
REQ-016 gnt SHALL be zero when stall=1, flush=1 or req=0; otherwise exactly one bit set, the first requesting index searched from ptr with wrap-around.
REQ-017 sel SHALL equal the index of the set gnt bit; sel SHALL be 0 when gnt=0.
REQ-018 A transfer occurs on a rising edge where gnt!=0; on that edge ptr SHALL become (sel+1) mod 8, wrapping 7 -> 0.
REQ-019 ptr SHALL NOT change on edges without a transfer.
REQ-020 On a transfer edge cdb_valid SHALL become 1, cdb_data/cdb_tag SHALL capture the selected unit's data_in/tag_in slice; latency req->cdb_valid = 1 cycle.
REQ-021 On edges with stall=1 and flush=0, cdb_valid/cdb_data/cdb_tag SHALL hold their values.
REQ-022 On edges with stall=0, flush=0 and no transfer, cdb_valid SHALL become 0; cdb_data/cdb_tag hold.
REQ-023 On edges with flush=1, cdb_valid SHALL become 0 regardless of stall or req; ptr holds; no grant occurs.
REQ-024 Handshake: unit i SHALL keep req[i], data and tag stable until it samples gnt[i]=1 at a clock edge; it drops or renews req the next cycle; the arbiter never grants a bit whose req is 0.
REQ-025 Starvation bound: a continuously asserted req[i] SHALL be granted within 8 non-stalled, non-flushed cycles.
REQ-026 gnt, sel SHALL depend only on req, stall, flush and ptr (no data path into control).

Reset
REQ-027 rst_n=0 SHALL asynchronously force ptr=0, cdb_valid=0, cdb_data=0, cdb_tag=0; gnt/sel follow REQ-016/017 (gnt=0 if req=0).
REQ-028 Reset asserted mid-broadcast SHALL drop cdb_valid immediately without waiting for clk; first grant after deassertion uses ptr=0.

Verification
REQ-029 Reset, req=8'h00 -> gnt=0, sel=0, cdb_valid=0 for all cycles; ptr stays 0.
REQ-030 req=8'hFF held 9 cycles from reset -> gnt sequence 01,02,04,...,80,01; sel 0..7,0; cdb_tag follows one cycle later.
REQ-031 ptr=6, req=8'h41 -> gnt=8'h40, sel=6; next cycle ptr=7, req=8'h01 -> gnt=8'h01 (wrap), ptr becomes 1.
REQ-032 Transfer of unit 3 (data 32'hDEADBEEF, tag 6'h15), then stall=1 for 3 cycles with req=8'h10 -> gnt=0, cdb_valid=1, cdb_data=32'hDEADBEEF held; stall=0 -> gnt=8'h10, next edge cdb_data=unit 4 data.
REQ-033 cdb_valid=1 then flush=1 with stall=1 and req=8'h04 -> gnt=0, next edge cdb_valid=0, ptr unchanged.
REQ-034 rst_n pulled low between edges while cdb_valid=1 -> cdb_valid=0 before next edge; after release req=8'h80 then req=8'h81 -> first grant 8'h80, then 8'h01.
